// File: rtl/temp_conv_pkg.sv
// Shared constants, FSM encoding and width helpers for the shared C->F conversion datapath.
package temp_conv_pkg;

    localparam int unsigned C_MUL = 9;
    localparam int unsigned C_DIV = 5;
    localparam int unsigned C_OFS = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // (2^cw - 1) * 9 < 2^(cw + 4), so four extra bits hold the product without loss.
    function automatic int unsigned dw_from_cw(input int unsigned cw);
        return cw + 4;
    endfunction

endpackage

// File: rtl/div_by_const_seq.sv
// Serial restoring divider by a constant: one quotient bit per cycle, MSB first.
module div_by_const_seq #(
    parameter int unsigned DW      = 12,
    parameter int unsigned DIVISOR = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    output logic          done,
    output logic [DW-1:0] quot
);

    localparam int unsigned RW   = $clog2(DIVISOR) + 1;
    localparam int unsigned CNTW = $clog2(DW);

    logic [RW-1:0]   rem;
    logic [DW-1:0]   q;
    logic [CNTW-1:0] cnt;
    logic            run;

    logic [RW-1:0]   trial;
    logic            ge;
    logic [RW-1:0]   rem_step;
    logic [DW-1:0]   q_step;

    // q doubles as the dividend shift register; quotient bits enter at the LSB
    always_comb begin
        trial    = {rem[RW-2:0], q[DW-1]};
        ge       = (trial >= RW'(DIVISOR));
        rem_step = ge ? (trial - RW'(DIVISOR)) : trial;
        q_step   = {q[DW-2:0], ge};
    end

    // Result of the final step is exposed in the same cycle it is computed
    assign done = run && (cnt == CNTW'(DW - 1));
    assign quot = q_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            q   <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            rem <= '0;
            q   <= dividend;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            rem <= rem_step;
            q   <= q_step;
            cnt <= cnt + CNTW'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/temp_conv_sched.sv
// Round-robin shared Celsius-to-Fahrenheit converter: F = floor(C*9/5) + 32, tagged by channel.
module temp_conv_sched
    import temp_conv_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 8,
    parameter int unsigned FW  = 9,
    parameter int unsigned DW  = dw_from_cw(CW)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH*CW-1:0]        req_celsius,
    output logic [NCH-1:0]           req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NCH)-1:0]   resp_chan,
    output logic [FW-1:0]            resp_fahr,
    output logic                     resp_over8,
    output logic                     busy
);

    localparam int unsigned CHW    = $clog2(NCH);
    localparam int unsigned MUL_SH = $clog2(C_MUL) - 1;

    logic [1:0]     state, state_nxt;
    logic [CHW-1:0] rr_ptr, rr_nxt;
    logic [CW-1:0]  c_q, c_nxt;
    logic [CHW-1:0] chan_q, chan_nxt;

    logic           resp_valid_nxt;
    logic [CHW-1:0] resp_chan_nxt;
    logic [FW-1:0]  resp_fahr_nxt;
    logic           resp_over8_nxt;
    logic           busy_nxt;

    logic           gnt_any;
    logic [CHW-1:0] gnt_idx;
    logic [CW-1:0]  gnt_cel;
    int unsigned    k;
    logic [CHW-1:0] kk;

    logic           div_start;
    logic [DW-1:0]  div_dividend;
    logic           div_done;
    logic [DW-1:0]  div_quot;

    // Round-robin scan starting at rr_ptr; first valid channel wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_cel = '0;
        k       = 0;
        kk      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            k  = (32'(rr_ptr) + i) % NCH;
            kk = CHW'(k);
            if (!gnt_any && req_valid[kk]) begin
                gnt_any = 1'b1;
                gnt_idx = kk;
                gnt_cel = CW'(req_celsius >> (k * CW));
            end
        end
    end

    assign req_ready = (state == ST_IDLE && gnt_any) ? (NCH'(1) << gnt_idx) : '0;

    // 9*C as (C << 3) + C
    assign div_dividend = (DW'(c_q) << MUL_SH) + DW'(c_q);

    div_by_const_seq #(
        .DW      (DW),
        .DIVISOR (C_DIV)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .done     (div_done),
        .quot     (div_quot)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_nxt      = state;
        rr_nxt         = rr_ptr;
        c_nxt          = c_q;
        chan_nxt       = chan_q;
        resp_chan_nxt  = resp_chan;
        resp_fahr_nxt  = resp_fahr;
        resp_over8_nxt = resp_over8;
        div_start      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    c_nxt     = gnt_cel;
                    chan_nxt  = gnt_idx;
                    rr_nxt    = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                div_start = 1'b1;
                state_nxt = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) begin
                    resp_fahr_nxt  = FW'(div_quot + DW'(C_OFS));
                    resp_over8_nxt = (FW'(div_quot + DW'(C_OFS)) > FW'(255));
                    resp_chan_nxt  = chan_q;
                    state_nxt      = ST_OUT;
                end
            end
            ST_OUT: begin
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        resp_valid_nxt = (state_nxt == ST_OUT);
        busy_nxt       = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            c_q        <= '0;
            chan_q     <= '0;
            resp_valid <= 1'b0;
            resp_chan  <= '0;
            resp_fahr  <= '0;
            resp_over8 <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            c_q        <= c_nxt;
            chan_q     <= chan_nxt;
            resp_valid <= resp_valid_nxt;
            resp_chan  <= resp_chan_nxt;
            resp_fahr  <= resp_fahr_nxt;
            resp_over8 <= resp_over8_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_temp_conv_sched.sv
// Directed bench for temp_conv_sched: conversions, round-robin order, stall and reset behaviour.
module tb_temp_conv_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned FW  = 9;

    logic                clk;
    logic                rst;
    logic [NCH-1:0]      req_valid;
    logic [NCH*CW-1:0]   req_celsius;
    logic [NCH-1:0]      req_ready;
    logic                resp_valid;
    logic                resp_ready;
    logic [1:0]          resp_chan;
    logic [FW-1:0]       resp_fahr;
    logic                resp_over8;
    logic                busy;

    int n_assert = 0;
    int n_fail   = 0;

    temp_conv_sched #(.NCH(NCH), .CW(CW), .FW(FW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_celsius (req_celsius),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_chan   (resp_chan),
        .resp_fahr   (resp_fahr),
        .resp_over8  (resp_over8),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cel(input int ch, input logic [CW-1:0] c);
        req_celsius[ch*CW +: CW] = c;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Single request on one channel with resp_ready held high
    task automatic do_req(input string tag, input int ch, input logic [CW-1:0] c,
                          input int exp_f, input logic exp_o8);
        int g;
        int lat;
        req_valid = NCH'(1) << ch;
        set_cel(ch, c);
        #1;
        g = 0;
        while (req_ready[ch] !== 1'b1 && g < 40) begin
            tick();
            g++;
        end
        check({tag, "_grant"}, 32'(req_ready), 32'(NCH'(1) << ch));
        tick();
        req_valid = '0;
        wait_resp(lat);
        check({tag, "_latency"}, 32'(lat), 32'd13);
        check({tag, "_chan"}, 32'(resp_chan), 32'(ch));
        check({tag, "_fahr"}, 32'(resp_fahr), 32'(exp_f));
        check({tag, "_over8"}, 32'(resp_over8), 32'(exp_o8));
        tick();
        check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int order [5];
        int exp_f [4];
        int ng, nr, cyc, last_acc, lat, nvalid;

        rst         = 1'b1;
        req_valid   = '0;
        req_celsius = '0;
        resp_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_resp_fahr",  32'(resp_fahr),  32'd0);
        check("rst_resp_chan",  32'(resp_chan),  32'd0);
        check("rst_resp_over8", 32'(resp_over8), 32'd0);
        check("rst_req_ready",  32'(req_ready),  32'd0);

        do_req("ch0_c100", 0, 8'd100, 212, 1'b0);
        do_req("ch1_c0",   1, 8'd0,   32,  1'b0);
        do_req("ch1_c1",   1, 8'd1,   33,  1'b0);
        do_req("ch1_c37",  1, 8'd37,  98,  1'b0);
        do_req("ch1_c255", 1, 8'd255, 491, 1'b1);

        // All channels contend continuously from rr_ptr = 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        order = '{0, 1, 2, 3, 0};
        exp_f = '{51, 71, 91, 392};
        set_cel(0, 8'd11);
        set_cel(1, 8'd22);
        set_cel(2, 8'd33);
        set_cel(3, 8'd200);
        req_valid = 4'b1111;
        #1;
        ng = 0; nr = 0; cyc = 0; last_acc = 0;
        while (nr < 5 && cyc < 200) begin
            if (ng < 5 && req_ready != '0) begin
                check("rr_grant", 32'(req_ready), 32'(NCH'(1) << order[ng]));
                if (ng > 0) check("rr_spacing", 32'(cyc - last_acc), 32'd15);
                last_acc = cyc;
                ng++;
            end
            tick();
            cyc++;
            if (ng == 5) req_valid = '0;
            if (resp_valid === 1'b1) begin
                check("rr_resp_chan", 32'(resp_chan), 32'(order[nr]));
                check("rr_resp_fahr", 32'(resp_fahr), 32'(exp_f[order[nr]]));
                nr++;
            end
        end
        check("rr_grants_seen", 32'(ng), 32'd5);
        check("rr_resps_seen",  32'(nr), 32'd5);
        tick();

        // Stall in OUT: rr_ptr is 1, only ch2 requests first
        req_valid = 4'b0100;
        set_cel(2, 8'd50);
        #1;
        check("stall_grant", 32'(req_ready), 32'b0100);
        tick();
        resp_ready = 1'b0;
        req_valid  = 4'b1001;
        set_cel(0, 8'd5);
        set_cel(3, 8'd100);
        wait_resp(lat);
        check("stall_latency", 32'(lat), 32'd13);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_fahr",  32'(resp_fahr),  32'd122);
            check("stall_chan",  32'(resp_chan),  32'd2);
            check("stall_over8", 32'(resp_over8), 32'd0);
            check("stall_busy",  32'(busy),       32'd1);
            check("stall_ready", 32'(req_ready),  32'd0);
        end
        resp_ready = 1'b1;
        tick();
        check("release_valid", 32'(resp_valid), 32'd0);
        check("release_grant", 32'(req_ready),  32'b1000);
        tick();
        req_valid = '0;
        wait_resp(lat);
        check("waiter_latency", 32'(lat),       32'd13);
        check("waiter_chan",    32'(resp_chan), 32'd3);
        check("waiter_fahr",    32'(resp_fahr), 32'd212);
        tick();

        // Reset in the middle of DIV: rr_ptr is 0, ch2 accepted then dropped
        req_valid = 4'b0100;
        set_cel(2, 8'd80);
        #1;
        check("drop_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        check("drop_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drop_resp_valid", 32'(resp_valid), 32'd0);
        check("drop_busy",       32'(busy),       32'd0);
        check("drop_fahr",       32'(resp_fahr),  32'd0);
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (resp_valid === 1'b1) nvalid++;
        end
        check("drop_no_response", 32'(nvalid), 32'd0);
        req_valid = 4'b1001;
        set_cel(0, 8'd100);
        set_cel(3, 8'd10);
        #1;
        check("post_rst_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        wait_resp(lat);
        check("post_rst_latency", 32'(lat),       32'd13);
        check("post_rst_chan",    32'(resp_chan), 32'd0);
        check("post_rst_fahr",    32'(resp_fahr), 32'd212);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
